// File: rtl/gba_irq_ctrl_pkg.sv
// Register records and source bit indices shared by the GBA interrupt controller.
// IE/IF share the word at 0x200; IME sits alone at 0x208.
package gba_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ACC_RW,
        ACC_RO,
        ACC_W1C
    } reg_access_t;

    typedef struct packed {
        logic [27:0] adr;
        logic [4:0]  upper;
        logic [4:0]  lower;
        logic [31:0] dflt;
        reg_access_t access;
    } reg_def_t;

    localparam reg_def_t REG_IE  = '{adr: 28'h200, upper: 5'd15, lower: 5'd0,  dflt: '0, access: ACC_RW};
    localparam reg_def_t REG_IF  = '{adr: 28'h200, upper: 5'd31, lower: 5'd16, dflt: '0, access: ACC_W1C};
    localparam reg_def_t REG_IME = '{adr: 28'h208, upper: 5'd0,  lower: 5'd0,  dflt: '0, access: ACC_RW};

    localparam int unsigned IRQ_BIT_VBLANK  = 0;
    localparam int unsigned IRQ_BIT_HBLANK  = 1;
    localparam int unsigned IRQ_BIT_VCOUNT  = 2;
    localparam int unsigned IRQ_BIT_TIMER0  = 3;
    localparam int unsigned IRQ_BIT_SERIAL  = 7;
    localparam int unsigned IRQ_BIT_DMA0    = 8;
    localparam int unsigned IRQ_BIT_KEYPAD  = 12;
    localparam int unsigned IRQ_BIT_GAMEPAK = 13;

endpackage

// File: rtl/gba_irq_delay.sv
// Fixed-length shift register carrying the IRQ request to the CPU; a clear flushes
// every stage so no stale request survives a reset.
module gba_irq_delay #(
    parameter int unsigned STAGES = 3
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] pipe_q;
    logic [STAGES-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = d_i;
        for (int unsigned i = 1; i < STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign q_o = pipe_q[STAGES-1];

endmodule

// File: rtl/gba_irq_ctrl.sv
// GBA interrupt controller: latches source pulses into IF, holds IE/IME on the I/O bus,
// and drives a delayed level IRQ plus an IME-independent halt-wake line.
module gba_irq_ctrl
    import gba_irq_ctrl_pkg::*;
#(
    parameter int unsigned IRQ_DELAY = 3,
    parameter int unsigned NUM_SRC   = 14
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [31:0] gb_bus_din,
    output logic [31:0] gb_bus_dout,
    input  logic [27:0] gb_bus_adr,
    input  logic        gb_bus_rnw,
    input  logic        gb_bus_ena,
    output logic        gb_bus_done,
    input  logic [1:0]  gb_bus_acc,
    input  logic [3:0]  gb_bus_be,
    input  logic        gb_bus_rst,
    input  logic        IRP_HBlank,
    input  logic        IRP_VBlank,
    input  logic        IRP_LCDStat,
    input  logic [3:0]  IRP_Timer,
    input  logic        IRP_Serial,
    input  logic        IRP_Joypad,
    input  logic        IRP_GamePak,
    input  logic [3:0]  IRP_DMA,
    output logic        cpu_irq,
    output logic        halt_wake,
    output logic [31:0] IRQ_debug
);

    logic [NUM_SRC-1:0] ie_q, ie_d;
    logic [NUM_SRC-1:0] if_q, if_d;
    logic               ime_q, ime_d;
    logic [31:0]        dout_q, dout_d;
    logic               dout_en_q;
    logic               pend_q;

    logic               rst;
    logic               wr_word0, wr_word1, rd_hit;
    logic [NUM_SRC-1:0] src, clr;
    logic               pend, req;
    logic               unused_bits;

    assign rst = reset | gb_bus_rst;

    assign src = {IRP_GamePak, IRP_Joypad, IRP_DMA, IRP_Serial, IRP_Timer,
                  IRP_LCDStat, IRP_HBlank, IRP_VBlank};

    assign wr_word0 = gb_bus_ena & ~gb_bus_rnw & (gb_bus_adr == REG_IE.adr);
    assign wr_word1 = gb_bus_ena & ~gb_bus_rnw & (gb_bus_adr == REG_IME.adr);
    assign rd_hit   = gb_bus_ena &  gb_bus_rnw &
                      ((gb_bus_adr == REG_IE.adr) | (gb_bus_adr == REG_IME.adr));

    always_comb begin
        ie_d   = ie_q;
        ime_d  = ime_q;
        clr    = '0;
        dout_d = dout_q;
        if (wr_word0) begin
            if (gb_bus_be[0]) ie_d[7:0]         = gb_bus_din[REG_IE.lower +: 8];
            if (gb_bus_be[1]) ie_d[NUM_SRC-1:8] = gb_bus_din[NUM_SRC-1:8];
            if (gb_bus_be[2]) clr[7:0]          = gb_bus_din[REG_IF.lower +: 8];
            if (gb_bus_be[3]) clr[NUM_SRC-1:8]  = gb_bus_din[NUM_SRC+15:24];
        end
        if (wr_word1 && gb_bus_be[0]) ime_d = gb_bus_din[0];
        // Source set is applied after the clear so a colliding pulse is never lost.
        if_d = (if_q & ~clr) | src;
        if (rd_hit) begin
            dout_d = (gb_bus_adr == REG_IME.adr) ? {31'b0, ime_q}
                                                 : {{(16-NUM_SRC){1'b0}}, if_q,
                                                    {(16-NUM_SRC){1'b0}}, ie_q};
        end
    end

    assign pend = |(ie_q & if_q);
    assign req  = ime_q & pend;

    always_ff @(posedge mclk) begin
        if (rst) begin
            ie_q      <= REG_IE.dflt[NUM_SRC-1:0];
            if_q      <= REG_IF.dflt[NUM_SRC-1:0];
            ime_q     <= REG_IME.dflt[0];
            dout_q    <= '0;
            dout_en_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            ie_q      <= ie_d;
            if_q      <= if_d;
            ime_q     <= ime_d;
            dout_q    <= dout_d;
            dout_en_q <= rd_hit;
            pend_q    <= pend;
        end
    end

    gba_irq_delay #(
        .STAGES(IRQ_DELAY)
    ) u_delay (
        .clk_i(mclk),
        .clr_i(rst),
        .d_i  (req),
        .q_o  (cpu_irq)
    );

    assign halt_wake   = pend_q;
    assign IRQ_debug   = {{(16-NUM_SRC){1'b0}}, if_q, {(16-NUM_SRC){1'b0}}, ie_q};
    assign gb_bus_dout = dout_en_q ? dout_q : 'z;
    assign gb_bus_done = 1'bz;

    assign unused_bits = ^{gb_bus_acc, gb_bus_din[31:NUM_SRC+16], gb_bus_din[15:NUM_SRC]};

endmodule

// File: tb/tb_gba_irq_ctrl.sv
// Self-checking bench for gba_irq_ctrl: vector table plus hand-written latency/reset sequences.
module tb_gba_irq_ctrl;

    localparam int unsigned DLY = 3;

    logic        mclk = 1'b0;
    logic        reset, gb_bus_rst;
    logic [31:0] gb_bus_din;
    logic [27:0] gb_bus_adr;
    logic        gb_bus_rnw, gb_bus_ena;
    logic [1:0]  gb_bus_acc;
    logic [3:0]  gb_bus_be;
    logic        IRP_HBlank, IRP_VBlank, IRP_LCDStat, IRP_Serial, IRP_Joypad, IRP_GamePak;
    logic [3:0]  IRP_Timer, IRP_DMA;
    wire  [31:0] gb_bus_dout;
    wire         gb_bus_done;
    logic        cpu_irq, halt_wake;
    logic [31:0] IRQ_debug;

    gba_irq_ctrl #(.IRQ_DELAY(DLY), .NUM_SRC(14)) dut (
        .mclk(mclk), .reset(reset), .gb_bus_din(gb_bus_din), .gb_bus_dout(gb_bus_dout),
        .gb_bus_adr(gb_bus_adr), .gb_bus_rnw(gb_bus_rnw), .gb_bus_ena(gb_bus_ena),
        .gb_bus_done(gb_bus_done), .gb_bus_acc(gb_bus_acc), .gb_bus_be(gb_bus_be),
        .gb_bus_rst(gb_bus_rst), .IRP_HBlank(IRP_HBlank), .IRP_VBlank(IRP_VBlank),
        .IRP_LCDStat(IRP_LCDStat), .IRP_Timer(IRP_Timer), .IRP_Serial(IRP_Serial),
        .IRP_Joypad(IRP_Joypad), .IRP_GamePak(IRP_GamePak), .IRP_DMA(IRP_DMA),
        .cpu_irq(cpu_irq), .halt_wake(halt_wake), .IRQ_debug(IRQ_debug)
    );

    always #5 mclk = ~mclk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic rd_hit_q = 1'b0;

    typedef struct {
        string       name;
        logic        ena;
        logic        rnw;
        logic [27:0] adr;
        logic [31:0] din;
        logic [3:0]  be;
        logic [13:0] src;
        logic [31:0] exp_rd;
        logic [31:0] exp_dbg;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Read scoreboard: a read accepted at one edge must show its data in the following cycle.
    always @(posedge mclk)
        rd_hit_q <= gb_bus_ena && gb_bus_rnw && (gb_bus_adr == 28'h200 || gb_bus_adr == 28'h208);

    always @(negedge mclk) begin
        logic [31:0] e;
        if (rd_hit_q) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got %h expected no read", gb_bus_dout);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", gb_bus_dout, e);
            end
        end
    end

    function automatic vec_t mk(input string nm, input logic ena, input logic rnw,
                                input logic [27:0] adr, input logic [31:0] din,
                                input logic [3:0] be, input logic [13:0] src,
                                input logic [31:0] exp_rd, input logic [31:0] exp_dbg);
        vec_t v;
        v.name = nm; v.ena = ena; v.rnw = rnw; v.adr = adr; v.din = din;
        v.be = be; v.src = src; v.exp_rd = exp_rd; v.exp_dbg = exp_dbg;
        return v;
    endfunction

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic drive_src(input logic [13:0] s);
        IRP_VBlank  = s[0];
        IRP_HBlank  = s[1];
        IRP_LCDStat = s[2];
        IRP_Timer   = s[6:3];
        IRP_Serial  = s[7];
        IRP_DMA     = s[11:8];
        IRP_Joypad  = s[12];
        IRP_GamePak = s[13];
    endtask

    task automatic idle_bus();
        gb_bus_ena = 1'b0; gb_bus_rnw = 1'b1; gb_bus_adr = '0; gb_bus_din = '0; gb_bus_be = '0;
    endtask

    task automatic bus_wr(input logic [27:0] adr, input logic [31:0] din, input logic [3:0] be);
        gb_bus_ena = 1'b1; gb_bus_rnw = 1'b0; gb_bus_adr = adr; gb_bus_din = din; gb_bus_be = be;
        tick();
        idle_bus();
    endtask

    task automatic bus_rd(input logic [27:0] adr, input logic [31:0] exp);
        gb_bus_ena = 1'b1; gb_bus_rnw = 1'b1; gb_bus_adr = adr; gb_bus_be = 4'hF;
        exp_q.push_back(exp);
        tick();
        idle_bus();
    endtask

    task automatic pulse(input logic [13:0] s);
        drive_src(s);
        tick();
        drive_src('0);
    endtask

    task automatic wait_irq(input logic lvl, output int lat);
        lat = 0;
        while (cpu_irq !== lvl && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic seen;
        logic [13:0] bit_v;

        gb_bus_acc = 2'b10;
        gb_bus_rst = 1'b0;
        reset      = 1'b1;
        idle_bus();
        drive_src('0);
        tick();
        tick();
        check("rst_dbg", IRQ_debug, 32'h0);
        check("rst_irq", {31'b0, cpu_irq}, 32'h0);
        check("rst_hw", {31'b0, halt_wake}, 32'h0);
        reset = 1'b0;
        tick();

        vecs.push_back(mk("ie_all",    1, 0, 28'h200, 32'h0000_FFFF, 4'b0011, 14'h0000, 32'h0, 32'h0000_3FFF));
        vecs.push_back(mk("rd_preset", 1, 1, 28'h200, 32'h0,         4'b1111, 14'h0001, 32'h0000_3FFF, 32'h0001_3FFF));
        vecs.push_back(mk("src_all",   0, 1, 28'h000, 32'h0,         4'b0000, 14'h3FFF, 32'h0, 32'h3FFF_3FFF));
        vecs.push_back(mk("rd_full",   1, 1, 28'h200, 32'h0,         4'b1111, 14'h0000, 32'h3FFF_3FFF, 32'h3FFF_3FFF));
        vecs.push_back(mk("w1c_b0",    1, 0, 28'h200, 32'h0001_0000, 4'b0100, 14'h0000, 32'h0, 32'h3FFE_3FFF));
        vecs.push_back(mk("w1c_hi",    1, 0, 28'h200, 32'hFFFF_0000, 4'b1000, 14'h0000, 32'h0, 32'h00FE_3FFF));
        vecs.push_back(mk("be_gate",   1, 0, 28'h200, 32'h00FF_0000, 4'b0011, 14'h0000, 32'h0, 32'h00FE_0000));
        vecs.push_back(mk("collide",   1, 0, 28'h200, 32'h0006_0000, 4'b0100, 14'h0002, 32'h0, 32'h00FA_0000));
        vecs.push_back(mk("rd_ime0",   1, 1, 28'h208, 32'h0,         4'b1111, 14'h0000, 32'h0, 32'h00FA_0000));
        vecs.push_back(mk("ime_set",   1, 0, 28'h208, 32'hFFFF_FFFF, 4'b0001, 14'h0000, 32'h0, 32'h00FA_0000));
        vecs.push_back(mk("rd_ime1",   1, 1, 28'h208, 32'h0,         4'b1111, 14'h0000, 32'h1, 32'h00FA_0000));
        vecs.push_back(mk("ime_nobe",  1, 0, 28'h208, 32'h0,         4'b1110, 14'h0000, 32'h0, 32'h00FA_0000));
        vecs.push_back(mk("rd_ime1b",  1, 1, 28'h208, 32'h0,         4'b1111, 14'h0000, 32'h1, 32'h00FA_0000));
        vecs.push_back(mk("wr_other",  1, 0, 28'h204, 32'hFFFF_FFFF, 4'b1111, 14'h0000, 32'h0, 32'h00FA_0000));
        vecs.push_back(mk("rd_after",  1, 1, 28'h200, 32'h0,         4'b1111, 14'h0000, 32'h00FA_0000, 32'h00FA_0000));
        vecs.push_back(mk("wr_both",   1, 0, 28'h200, 32'hFFFF_FFFF, 4'b1111, 14'h0000, 32'h0, 32'h0000_3FFF));
        vecs.push_back(mk("ie_clr",    1, 0, 28'h200, 32'h0,         4'b0011, 14'h0000, 32'h0, 32'h0000_0000));
        vecs.push_back(mk("ime_clr",   1, 0, 28'h208, 32'h0,         4'b0001, 14'h0000, 32'h0, 32'h0000_0000));
        vecs.push_back(mk("rd_ime0b",  1, 1, 28'h208, 32'h0,         4'b1111, 14'h0000, 32'h0, 32'h0000_0000));

        foreach (vecs[i]) begin
            gb_bus_ena = vecs[i].ena; gb_bus_rnw = vecs[i].rnw; gb_bus_adr = vecs[i].adr;
            gb_bus_din = vecs[i].din; gb_bus_be = vecs[i].be;
            drive_src(vecs[i].src);
            if (vecs[i].ena && vecs[i].rnw && (vecs[i].adr == 28'h200 || vecs[i].adr == 28'h208))
                exp_q.push_back(vecs[i].exp_rd);
            tick();
            idle_bus();
            drive_src('0);
            check(vecs[i].name, IRQ_debug, vecs[i].exp_dbg);
        end
        tick();

        // Each source lands on its own IF bit.
        for (int i = 0; i < 14; i++) begin
            bit_v = 14'(1) << i;
            pulse(bit_v);
            check($sformatf("src_bit%0d", i), IRQ_debug, {2'b0, bit_v, 16'h0});
            bus_wr(28'h200, 32'hFFFF_0000, 4'b1100);
        end

        // VBlank pulse with IE/IME enabled: assertion and deassertion latency.
        bus_wr(28'h200, 32'h0000_0001, 4'b0001);
        bus_wr(28'h208, 32'h0000_0001, 4'b0001);
        pulse(14'h0001);
        check("vb_if", IRQ_debug, 32'h0001_0001);
        check("vb_hw_early", {31'b0, halt_wake}, 32'h0);
        wait_irq(1'b1, lat);
        check("vb_irq_lat", 32'(lat), 32'(DLY));
        check("vb_hw", {31'b0, halt_wake}, 32'h1);
        bus_wr(28'h200, 32'h0001_0000, 4'b0100);
        check("vb_if_clr", IRQ_debug, 32'h0000_0001);
        wait_irq(1'b0, lat);
        check("vb_irq_fall", 32'(lat), 32'(DLY));
        check("vb_hw_fall", {31'b0, halt_wake}, 32'h0);

        // IME gating: halt_wake follows pend, cpu_irq waits for IME.
        bus_wr(28'h208, 32'h0, 4'b0001);
        bus_wr(28'h200, 32'h0000_0100, 4'b0010);
        pulse(14'h0100);
        check("dma_hw_early", {31'b0, halt_wake}, 32'h0);
        tick();
        check("dma_hw", {31'b0, halt_wake}, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_irq !== 1'b0) seen = 1'b1;
        end
        check("dma_ime_gate", {31'b0, seen}, 32'h0);
        bus_wr(28'h208, 32'h0000_0001, 4'b0001);
        wait_irq(1'b1, lat);
        check("dma_ime_lat", 32'(lat), 32'(DLY));

        // Reset with cpu_irq high: immediate drop, no tail.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_irq", {31'b0, cpu_irq}, 32'h0);
        check("rst_mid_hw", {31'b0, halt_wake}, 32'h0);
        check("rst_mid_dbg", IRQ_debug, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_irq !== 1'b0) seen = 1'b1;
        end
        check("rst_no_tail", {31'b0, seen}, 32'h0);
        bus_rd(28'h208, 32'h0);

        // Bus register reset behaves the same.
        bus_wr(28'h200, 32'h0000_0001, 4'b0001);
        bus_wr(28'h208, 32'h0000_0001, 4'b0001);
        pulse(14'h0001);
        wait_irq(1'b1, lat);
        check("bus_rst_pre", 32'(lat), 32'(DLY));
        gb_bus_rst = 1'b1;
        tick();
        gb_bus_rst = 1'b0;
        check("bus_rst_irq", {31'b0, cpu_irq}, 32'h0);
        check("bus_rst_dbg", IRQ_debug, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_irq !== 1'b0) seen = 1'b1;
        end
        check("bus_rst_tail", {31'b0, seen}, 32'h0);

        tick();
        tick();
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
